tx_source_mux: RTL
==================

# tx_source_mux

Byte source selector placed directly upstream of the UART transmitter. It buffers echo bytes from the UART receiver in a small FIFO and, on request from the `SW` switch, streams a fixed parameterised message. It presents one byte at a time to the transmitter through a start/done handshake. The message always has priority; echo bytes that arrive meanwhile are held and sent afterwards in arrival order.

## Interface
- `MSG_LEN`, 13: message length in bytes, 1–32.
- `MSG`, "Hello world!\n": message, `8*MSG_LEN` bits, Verilog string-literal order.
- `FIFO_DEPTH`, 8: echo FIFO depth; power of two, 2–64.

- `clk` in 1: single clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `SW` in 1: asynchronous message-request level; synchronised internally.
- `rx_word` in 8: received byte; valid only with `rx_valid`.
- `rx_valid` in 1: one-cycle pulse from the receiver.
- `tx_word` out 8: byte offered to the transmitter.
- `tx_start` out 1: level; high while a byte is offered.
- `tx_done` in 1: one-cycle pulse from the transmitter when the byte has been sent.
- `msg_busy` out 1: high from message acceptance until the last byte's `tx_done`.
- `fifo_overflow` out 1: sticky; set when an echo byte is dropped; cleared only by `rst`.

## Operation
- **Reset:** `tx_word`=0x00, `tx_start`=0, `msg_busy`=0, `fifo_overflow`=0. The FIFO is empty, state is IDLE, and the synchroniser flops are 0. Reset takes effect immediately, including mid-byte.
- **FIFO push:** on `rx_valid`, push `rx_word` if not full. If full, drop the byte and set `fifo_overflow`.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - When the FIFO is full, a push in the same cycle as a pop is accepted.
- **Message request:** 2-flop synchroniser plus edge detect on `SW`. A rising edge sets `msg_pend`. The edge is ignored while `msg_busy`=1 or `msg_pend`=1. Holding `SW` high produces exactly one message.
- **State machine:** IDLE, MSG_SEND, ECHO_SEND, GAP.
  - **IDLE:** if `msg_pend`, clear it, set index=0, `msg_busy`=1, load `MSG[8*MSG_LEN-1 -: 8]`, go to MSG_SEND. Otherwise, if the FIFO is not empty, pop the head into `tx_word` and go to ECHO_SEND. Otherwise stay in IDLE.
  - **MSG_SEND / ECHO_SEND:** `tx_start`=1 and `tx_word` is stable. On `tx_done`, go to GAP.
  - **GAP:** `tx_start`=0 for exactly one cycle.
    - If `msg_busy` and index<`MSG_LEN-1`: increment index, load the next byte, go to MSG_SEND.
    - If `msg_busy` and index=`MSG_LEN-1`: clear `msg_busy`, go to IDLE.
    - Otherwise go to IDLE.
- **Byte order:** message byte i = `MSG[8*(MSG_LEN-i)-1 -: 8]`.
- **Index:** `$clog2(MSG_LEN+1)` bits; it never wraps.
- **FIFO pointers:** `$clog2(FIFO_DEPTH)` bits plus one extra bit for full/empty; they wrap modulo `2*FIFO_DEPTH`.
- **Stray handshakes:** `tx_done` outside the SEND states is ignored.
- **Arrival during a message:** an `SW` edge arriving during the last message byte is ignored (busy still high). An `SW` edge arriving in the final GAP starts a new message from IDLE.

## Timing
- **Echo latency:** `rx_valid` sampled at edge N → FIFO written at N → IDLE pops at N+1 → `tx_start` high after edge N+1.
- **Message latency:** `SW` first sampled high at edge 0 → synchroniser output at 1 → `msg_pend` at 2 → `tx_start` high after edge 3 (when IDLE). If a byte is in flight, the message starts from the IDLE following that byte's GAP.
- **Release:** `tx_done` sampled at edge M → `tx_start` low after M.
- **Next message byte:** `tx_start` high again after M+1.
- **Inter-byte gap:** every transmitted byte is preceded by at least one cycle with `tx_start`=0.
- **Output registers:** all outputs are registered; there are no combinational input→output paths.

## Structure
- Package `uart_pkg` contains:
  - the state enum (IDLE, MSG_SEND, ECHO_SEND, GAP);
  - `BYTE_W`=8;
  - the default message constant.
- Sub-module `byte_fifo`, parameterised by depth: synchronous write/read, `full`/`empty`, and first-word data presented at the read port.
- Arbitration, synchroniser and the message index live in the top level.

## Test plan
- **Reset:** assert `rst` mid-simulation → all outputs at their reset values within the same cycle; `tx_start`=0 with no clock edge required.
- **Single echo:** `rx_valid` with 0x41; transmitter model returns `tx_done` after 10 cycles → `tx_word`=0x41 and `tx_start` high after N+1, low after the `tx_done` edge, exactly one byte sent.
- **Message:** pulse `SW` (held high for 100 cycles) → 48 65 6C 6C 6F 20 77 6F 72 6C 64 21 0A sent once, one GAP cycle between bytes, `msg_busy` falls after the 0x0A `tx_done`.
- **Echo during message:** push 0x31 and 0x32 while byte 3 is in flight → both are sent after 0x0A, in order 0x31 then 0x32.
- **Overflow:** withhold `tx_done`, push 10 bytes 0x00–0x09 → 0x00 in flight, 0x01–0x08 buffered, 0x09 dropped, `fifo_overflow`=1. Release `tx_done` → 0x00–0x08 sent in order; `fifo_overflow` stays 1.
- **Reset mid-message:** assert `rst` during byte 5 → all state clears. Afterwards, a new `SW` edge restarts from 0x48; without a new edge, no byte is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side byte source selector.
package uart_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEFAULT_MSG_LEN = 13;
  localparam logic [8*DEFAULT_MSG_LEN-1:0] DEFAULT_MSG = "Hello world!\n";

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MSG_SEND  = 2'd1,
    ECHO_SEND = 2'd2,
    GAP       = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tx_source_mux_if.sv
// Byte-level signals between the receiver, the source selector and the transmitter.
interface tx_source_mux_if;
  import uart_pkg::*;

  logic              SW;
  logic [BYTE_W-1:0] rx_word;
  logic              rx_valid;
  logic [BYTE_W-1:0] tx_word;
  logic              tx_start;
  logic              tx_done;
  logic              msg_busy;
  logic              fifo_overflow;

  modport master (
    input  SW, rx_word, rx_valid, tx_done,
    output tx_word, tx_start, msg_busy, fifo_overflow
  );

  modport slave (
    output SW, rx_word, rx_valid, tx_done,
    input  tx_word, tx_start, msg_busy, fifo_overflow
  );

endinterface

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with the head word always visible on the read port.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic              wr_en_s;
  logic              rd_en_s;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot this cycle, so a full FIFO still accepts a simultaneous push.
  assign rd_en_s = pop_i && !empty_o;
  assign wr_en_s = push_i && (!full_o || rd_en_s);

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/tx_source_mux.sv
// Selects between a fixed message and buffered echo bytes and hands them one at a
// time to the UART transmitter; the message wins, echoes queue up behind it.
module tx_source_mux
  import uart_pkg::*;
#(
  parameter int                   MSG_LEN    = DEFAULT_MSG_LEN,
  parameter logic [8*MSG_LEN-1:0] MSG        = DEFAULT_MSG,
  parameter int                   FIFO_DEPTH = 8
) (
  input logic            clk,
  input logic            rst,
  tx_source_mux_if.master io
);

  localparam int                IDX_W    = $clog2(MSG_LEN + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MSG_LEN - 1);

  tx_state_e         state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic              msg_busy_q;
  logic              msg_pend_q;
  logic              tx_start_q;
  logic [BYTE_W-1:0] tx_word_q;
  logic              fifo_overflow_q;
  logic              sw_meta_q, sw_sync_q, sw_prev_q;

  logic              fifo_full_s, fifo_empty_s, fifo_pop_s, drop_s;
  logic [BYTE_W-1:0] fifo_head_s;
  logic              sw_rise_s, final_gap_s, accept_s;
  logic [8*MSG_LEN-1:0] msg_shift_s;
  logic [BYTE_W-1:0] msg_byte_s;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (io.rx_valid),
    .wdata_i (io.rx_word),
    .pop_i   (fifo_pop_s),
    .rdata_o (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign fifo_pop_s  = (state_q == IDLE) && !msg_pend_q && !fifo_empty_s;
  assign drop_s      = io.rx_valid && fifo_full_s && !fifo_pop_s;
  assign sw_rise_s   = sw_sync_q && !sw_prev_q;
  // The closing GAP of a message already counts as free, so a request there is kept.
  assign final_gap_s = (state_q == GAP) && msg_busy_q && (idx_q == LAST_IDX);
  assign accept_s    = sw_rise_s && !msg_pend_q && (!msg_busy_q || final_gap_s);

  // Index of the message byte to be loaded on this edge, and that byte.
  always_comb begin
    idx_d = '0;
    if (state_q == IDLE) begin
      idx_d = '0;
    end else begin
      idx_d = idx_q + IDX_W'(1);
    end
    msg_shift_s = MSG << {idx_d, 3'b000};
    msg_byte_s  = msg_shift_s[8*MSG_LEN-1 -: 8];
  end

  // Request synchroniser, arbitration FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      msg_busy_q      <= 1'b0;
      msg_pend_q      <= 1'b0;
      tx_start_q      <= 1'b0;
      tx_word_q       <= 8'h00;
      fifo_overflow_q <= 1'b0;
      sw_meta_q       <= 1'b0;
      sw_sync_q       <= 1'b0;
      sw_prev_q       <= 1'b0;
    end else begin
      sw_meta_q <= io.SW;
      sw_sync_q <= sw_meta_q;
      sw_prev_q <= sw_sync_q;
      if (drop_s) begin
        fifo_overflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (msg_pend_q) begin
            msg_pend_q <= 1'b0;
            idx_q      <= idx_d;
            msg_busy_q <= 1'b1;
            tx_word_q  <= msg_byte_s;
            tx_start_q <= 1'b1;
            state_q    <= MSG_SEND;
          end else if (!fifo_empty_s) begin
            tx_word_q  <= fifo_head_s;
            tx_start_q <= 1'b1;
            state_q    <= ECHO_SEND;
          end else begin
            state_q    <= IDLE;
          end
        end
        MSG_SEND, ECHO_SEND: begin
          if (io.tx_done) begin
            tx_start_q <= 1'b0;
            state_q    <= GAP;
          end
        end
        GAP: begin
          if (msg_busy_q && (idx_q < LAST_IDX)) begin
            idx_q      <= idx_d;
            tx_word_q  <= msg_byte_s;
            tx_start_q <= 1'b1;
            state_q    <= MSG_SEND;
          end else begin
            msg_busy_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
      if (accept_s) begin
        msg_pend_q <= 1'b1;
      end
    end
  end

  assign io.tx_word       = tx_word_q;
  assign io.tx_start      = tx_start_q;
  assign io.msg_busy      = msg_busy_q;
  assign io.fifo_overflow = fifo_overflow_q;

endmodule
